front_panel_ctrl: RTL and testbench
===================================

// Module: front_panel_ctrl
// PURPOSE
// Parametrised front-panel controller for the PDP-8 board: per-button debounce with one-shot
// and optional auto-repeat pulses, synchronous run/halt latch, and a wrapping display-select register.
// Also drives a multiplexed N-digit 7-segment display in octal or hex.
// Sits between board I/O (switches, buttons, anodes/cathodes) and main_bus front-panel signals.
// PARAMETERS
// NUM_BTN        5     number of momentary buttons (>=1)
// DEB_CYCLES     5     cycles a synchronised input must differ from stable value before accepted (>=1)
// REPEAT_CYCLES  0     auto-repeat period while button held; 0 disables repeat
// NUM_DIGITS     4     display digits driven (1..8)
// DIGIT_BITS     3     bits per digit: 3 = octal, 4 = hex
// SCAN_DIV       2**18 cycles each digit is lit (>=1)
// NUM_SEL        4     display-select modes; disp_sel wraps modulo NUM_SEL (>=1)
// DISP_BTN       4     index of button whose pulse advances disp_sel
// PORTS
// clock      in   1                      system clock
// resetN     in   1                      async active-low reset
// btn_raw    in   NUM_BTN                raw, unsynchronised buttons, active high
// run_sw     in   1                      raw run switch, active high
// halt       in   1                      CPU halt request, synchronous, active high
// disp_val   in   NUM_DIGITS*DIGIT_BITS  value to display; digit 0 = LSBs
// dp_mask    in   NUM_DIGITS             1 = light decimal point of that digit
// btn_pulse  out  NUM_BTN                one-cycle press / repeat pulses
// btn_level  out  NUM_BTN                debounced button levels
// run        out  1                      run latch
// disp_sel   out  $clog2(NUM_SEL) (min 1)   current display-select mode
// an         out  NUM_DIGITS             digit anodes, active low, one-hot-low
// seg        out  7                      cathodes {g..a}, active low
// dp         out  1                      decimal point cathode, active low
// BEHAVIOUR
// - Reset (async, resetN=0): sync flops, stable levels, counters, btn_pulse, btn_level, run,
//   disp_sel, scan counter = 0; digit index = 0 so an = ~1 (digit 0 lit).
// - Each button and run_sw: 2-flop synchroniser -> debounce counter. While sync != stable, count++;
//   when count == DEB_CYCLES-1 and still differing, stable <= sync and count <= 0. Any cycle with
//   sync == stable clears count (glitch shorter than DEB_CYCLES is rejected).
// - Latency: raw held steady from edge k -> stable changes at edge k+DEB_CYCLES+1; btn_pulse high
//   for the one cycle following that edge.
// - btn_pulse[i] = 1 for exactly one cycle on stable 0->1; none on release.
// - Repeat (REPEAT_CYCLES>0): while stable stays 1, pulse again every REPEAT_CYCLES cycles after
//   the previous pulse; repeat counter clears on release.
// - Independent buttons: simultaneous presses give simultaneous pulses.
// - run: rising edge of debounced run_sw sets run; debounced run_sw = 0 clears run;
//   halt = 1 clears run. halt wins over a same-cycle set. halt while already 0 has no effect.
//   After a halt, run stays 0 until run_sw is released and pressed again.
// - disp_sel: btn_pulse[DISP_BTN] increments; NUM_SEL-1 wraps to 0. Takes effect the cycle after
//   the pulse.
// - Scan: counter counts 0..SCAN_DIV-1, then advances digit index modulo NUM_DIGITS.
//   - an[d] = 0 only for the current digit.
//   - seg decodes disp_val digit (hex 0-F; octal uses 0-7).
//   - dp = ~dp_mask[digit].
//   - an/seg/dp are registered and all update on the same edge.
// - Reset mid-press or mid-debounce: everything returns to reset values; a button still held after
//   reset re-debounces and emits one new pulse.
// TESTING
// - Raw glitch of DEB_CYCLES-1 cycles on btn_raw[0] -> no btn_pulse, btn_level stays 0.
// - btn_raw[2] held 20 cycles (DEB_CYCLES=5, REPEAT_CYCLES=0) -> single pulse exactly 7 cycles after
//   the rise; no pulse on release.
// - REPEAT_CYCLES=8, hold btn 40 cycles -> first pulse at +7, then at +15, +23, +31, +39.
// - run_sw 0->1 -> run=1 after debounce; halt pulse -> run=0 next cycle;
//   halt same cycle as set -> run stays 0.
// - 5 DISP_BTN presses, NUM_SEL=4 -> disp_sel 1,2,3,0,1.
// - disp_val=12'o7350, SCAN_DIV=2, DIGIT_BITS=3 -> an sequence 1110,1101,1011,0111 every 2 cycles;
//   seg 0x40,0x12,0x30,0x78.
// - resetN low mid-debounce -> all outputs reset; held button yields one pulse after release of reset.

Source files
------------

// File: rtl/front_panel_ctrl_if.sv
// front_panel_ctrl_if: board-side front-panel signal bundle.
// master drives switches/buttons/display data, slave is the controller.
interface front_panel_ctrl_if #(
  parameter int NUM_BTN    = 5,
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_BITS = 3,
  parameter int NUM_SEL    = 4
);
  localparam int SELW = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;

  logic [NUM_BTN-1:0]               btn_raw;
  logic                             run_sw;
  logic                             halt;
  logic [NUM_DIGITS*DIGIT_BITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]            dp_mask;

  logic [NUM_BTN-1:0]    btn_pulse;
  logic [NUM_BTN-1:0]    btn_level;
  logic                  run;
  logic [SELW-1:0]       disp_sel;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output btn_raw, run_sw, halt, disp_val, dp_mask,
    input  btn_pulse, btn_level, run, disp_sel, an, seg, dp
  );

  modport slave (
    input  btn_raw, run_sw, halt, disp_val, dp_mask,
    output btn_pulse, btn_level, run, disp_sel, an, seg, dp
  );
endinterface

// File: rtl/front_panel_ctrl.sv
// front_panel_ctrl: debounced buttons with repeat, run latch,
// display-select register and multiplexed 7-segment scan.
module front_panel_ctrl #(
  parameter int NUM_BTN       = 5,
  parameter int DEB_CYCLES    = 5,
  parameter int REPEAT_CYCLES = 0,
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_BITS    = 3,
  parameter int SCAN_DIV      = 2**18,
  parameter int NUM_SEL       = 4,
  parameter int DISP_BTN      = 4
) (
  input  logic              clock,
  input  logic              resetN,
  front_panel_ctrl_if.slave bus
);
  localparam int NCH  = NUM_BTN + 1;
  localparam int DEBW = $clog2(DEB_CYCLES + 1);
  localparam int REPW =
    (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int SELW = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
  localparam int DIGW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNTW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NCH-1:0]        s1_q, s2_q, stb_q, stb_d;
  logic [DEBW-1:0]       deb_q [NCH];
  logic [DEBW-1:0]       deb_d [NCH];
  logic [REPW-1:0]       rep_q [NUM_BTN];
  logic [REPW-1:0]       rep_d [NUM_BTN];
  logic [NUM_BTN-1:0]    pulse_q, pulse_d;
  logic                  run_q, run_d;
  logic [SELW-1:0]       sel_q, sel_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [DIGW-1:0]       dig_q, dig_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [3:0]            nib;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'ha: s = 7'h08;
      4'hb: s = 7'h03;
      4'hc: s = 7'h46;
      4'hd: s = 7'h21;
      4'he: s = 7'h06;
      default: s = 7'h0e;
    endcase
    return s;
  endfunction

  // channel NUM_BTN is the run switch, debounced like a button
  always_comb begin
    stb_d = stb_q;
    for (int i = 0; i < NCH; i++) begin
      deb_d[i] = '0;
      if (s2_q[i] != stb_q[i]) begin
        if (deb_q[i] == DEBW'(DEB_CYCLES - 1))
          stb_d[i] = s2_q[i];
        else
          deb_d[i] = deb_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      pulse_d[i] = stb_d[i] & ~stb_q[i];
      rep_d[i]   = '0;
      if (REPEAT_CYCLES > 0 && stb_q[i] && stb_d[i]) begin
        if (rep_q[i] == REPW'(REPEAT_CYCLES - 1))
          pulse_d[i] = 1'b1;
        else
          rep_d[i] = rep_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    run_d = run_q;
    if (stb_d[NUM_BTN] && !stb_q[NUM_BTN]) run_d = 1'b1;
    if (!stb_d[NUM_BTN]) run_d = 1'b0;
    if (bus.halt) run_d = 1'b0;

    sel_d = sel_q;
    if (pulse_q[DISP_BTN])
      sel_d = (sel_q == SELW'(NUM_SEL - 1)) ? '0
                                            : sel_q + 1'b1;

    cnt_d = cnt_q + 1'b1;
    dig_d = dig_q;
    if (cnt_q == CNTW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      dig_d = (dig_q == DIGW'(NUM_DIGITS - 1)) ? '0
                                               : dig_q + 1'b1;
    end

    // display outputs follow the next digit so they move together
    an_d  = ~(NUM_DIGITS'(1) << dig_d);
    nib   = 4'(bus.disp_val[dig_d*DIGIT_BITS +: DIGIT_BITS]);
    seg_d = seg_of(nib);
    dp_d  = ~bus.dp_mask[dig_d];
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1_q    <= '0;
      s2_q    <= '0;
      stb_q   <= '0;
      for (int i = 0; i < NCH; i++) deb_q[i] <= '0;
      for (int i = 0; i < NUM_BTN; i++) rep_q[i] <= '0;
      pulse_q <= '0;
      run_q   <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      an_q    <= ~NUM_DIGITS'(1);
      seg_q   <= 7'h7f;
      dp_q    <= 1'b1;
    end else begin
      s1_q    <= {bus.run_sw, bus.btn_raw};
      s2_q    <= s1_q;
      stb_q   <= stb_d;
      deb_q   <= deb_d;
      rep_q   <= rep_d;
      pulse_q <= pulse_d;
      run_q   <= run_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.btn_pulse = pulse_q;
  assign bus.btn_level = stb_q[NUM_BTN-1:0];
  assign bus.run       = run_q;
  assign bus.disp_sel  = sel_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
endmodule

// File: tb/tb_front_panel_ctrl.sv
// tb_front_panel_ctrl: two controller instances (no repeat / repeat 8)
// against a history-based reference model plus directed sequences.
module tb_front_panel_ctrl;
  logic        clk = 1'b0;
  logic        resetN;
  logic [4:0]  btn_raw;
  logic        run_sw;
  logic        halt;
  logic [11:0] dval_a;
  logic [15:0] dval_b;
  logic [3:0]  dpm;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  front_panel_ctrl_if #(.NUM_BTN(5), .NUM_DIGITS(4),
    .DIGIT_BITS(3), .NUM_SEL(4)) fa ();
  front_panel_ctrl_if #(.NUM_BTN(5), .NUM_DIGITS(4),
    .DIGIT_BITS(4), .NUM_SEL(3)) fb ();

  assign fa.btn_raw  = btn_raw;
  assign fa.run_sw   = run_sw;
  assign fa.halt     = halt;
  assign fa.disp_val = dval_a;
  assign fa.dp_mask  = dpm;
  assign fb.btn_raw  = btn_raw;
  assign fb.run_sw   = run_sw;
  assign fb.halt     = halt;
  assign fb.disp_val = dval_b;
  assign fb.dp_mask  = dpm;

  front_panel_ctrl #(.NUM_BTN(5), .DEB_CYCLES(5),
    .REPEAT_CYCLES(0), .NUM_DIGITS(4), .DIGIT_BITS(3),
    .SCAN_DIV(2), .NUM_SEL(4), .DISP_BTN(4)) dut_a (
    .clock(clk), .resetN(resetN), .bus(fa.slave));

  front_panel_ctrl #(.NUM_BTN(5), .DEB_CYCLES(5),
    .REPEAT_CYCLES(8), .NUM_DIGITS(4), .DIGIT_BITS(4),
    .SCAN_DIV(3), .NUM_SEL(3), .DISP_BTN(4)) dut_b (
    .clock(clk), .resetN(resetN), .bus(fb.slave));

  // reference model: raw history per edge, timestamps for repeat
  logic [5:0] rawh[$];
  logic [5:0] m_stb;
  logic [4:0] mp_a, mp_b;
  int         lastp [5];
  logic       m_run;
  int         msel_a, msel_b, n;
  logic [6:0] seg_tab [16];

  function automatic void model_reset();
    rawh.delete();
    m_stb  = '0;
    mp_a   = '0;
    mp_b   = '0;
    m_run  = 1'b0;
    msel_a = 0;
    msel_b = 0;
    n      = 0;
    for (int b = 0; b < 5; b++) lastp[b] = 0;
  endfunction

  function automatic void model_edge();
    logic [5:0] old;
    if (!resetN) begin
      model_reset();
      return;
    end
    n++;
    rawh.push_back({run_sw, btn_raw});
    if (mp_a[4]) msel_a = (msel_a + 1) % 4;
    if (mp_b[4]) msel_b = (msel_b + 1) % 3;
    old = m_stb;
    // accept when the synchronised value differed on the last 5 edges
    for (int c = 0; c < 6; c++) begin
      bit flip = 1'b1;
      for (int j = 0; j < 5; j++) begin
        int  k = n - 3 - j;
        logic s = (k >= 0) ? rawh[k][c] : 1'b0;
        if (s == m_stb[c]) flip = 1'b0;
      end
      if (flip) m_stb[c] = ~m_stb[c];
    end
    for (int b = 0; b < 5; b++) begin
      mp_a[b] = m_stb[b] & ~old[b];
      mp_b[b] = mp_a[b] |
        (old[b] & m_stb[b] & ((n - lastp[b]) == 8));
      if (mp_b[b]) lastp[b] = n;
    end
    if (halt) m_run = 1'b0;
    else if (m_stb[5] && !old[5]) m_run = 1'b1;
    else if (!m_stb[5]) m_run = 1'b0;
  endfunction

  function automatic logic [24:0] exp_a();
    int dig = (n / 2) % 4;
    logic [3:0] v = 4'((dval_a >> (3 * dig)) & 12'h7);
    logic [3:0] an = ~(4'b1 << dig);
    logic [6:0] sg = (n == 0) ? 7'h7f : seg_tab[v];
    logic dp = (n == 0) ? 1'b1 : ~dpm[dig];
    return {mp_a, m_stb[4:0], m_run, 2'(msel_a), an, sg, dp};
  endfunction

  function automatic logic [24:0] exp_b();
    int dig = (n / 3) % 4;
    logic [3:0] v = 4'((dval_b >> (4 * dig)) & 16'hf);
    logic [3:0] an = ~(4'b1 << dig);
    logic [6:0] sg = (n == 0) ? 7'h7f : seg_tab[v];
    logic dp = (n == 0) ? 1'b1 : ~dpm[dig];
    return {mp_b, m_stb[4:0], m_run, 2'(msel_b), an, sg, dp};
  endfunction

  function automatic logic [24:0] got_a();
    return {fa.btn_pulse, fa.btn_level, fa.run, fa.disp_sel,
            fa.an, fa.seg, fa.dp};
  endfunction

  function automatic logic [24:0] got_b();
    return {fb.btn_pulse, fb.btn_level, fb.run, fb.disp_sel,
            fb.an, fb.seg, fb.dp};
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("model_a", 64'(got_a()), 64'(exp_a()));
    check("model_b", 64'(got_b()), 64'(exp_b()));
  endtask

  typedef struct packed {
    logic [3:0] dpm;
    logic [3:0] an_a;
    logic [6:0] seg_a;
    logic       dp_a;
    logic [3:0] an_b;
    logic [6:0] seg_b;
    logic       dp_b;
  } scan_vec_t;

  scan_vec_t tab [9];
  int qa[$];
  int qb[$];
  int cnt;
  int pos;

  initial begin
    int exp_b_pos [5];
    int exp_sel [5];
    exp_b_pos = '{7, 15, 23, 31, 39};
    exp_sel   = '{1, 2, 3, 0, 1};
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                7'h46, 7'h21, 7'h06, 7'h0e};
    // 7350 octal on A, C9A2 hex on B; rows are edges 1..9
    tab[0] = '{4'b0101, 4'he, 7'h40, 1'b0, 4'he, 7'h24, 1'b0};
    tab[1] = '{4'b0101, 4'hd, 7'h12, 1'b1, 4'he, 7'h24, 1'b0};
    tab[2] = '{4'b0101, 4'hd, 7'h12, 1'b1, 4'hd, 7'h08, 1'b1};
    tab[3] = '{4'b0101, 4'hb, 7'h30, 1'b0, 4'hd, 7'h08, 1'b1};
    tab[4] = '{4'b1010, 4'hb, 7'h30, 1'b1, 4'hd, 7'h08, 1'b0};
    tab[5] = '{4'b1010, 4'h7, 7'h78, 1'b0, 4'hb, 7'h10, 1'b1};
    tab[6] = '{4'b1010, 4'h7, 7'h78, 1'b0, 4'hb, 7'h10, 1'b1};
    tab[7] = '{4'b1010, 4'he, 7'h40, 1'b1, 4'hb, 7'h10, 1'b1};
    tab[8] = '{4'b1010, 4'he, 7'h40, 1'b1, 4'h7, 7'h46, 1'b0};

    btn_raw = '0;
    run_sw  = 1'b0;
    halt    = 1'b0;
    dval_a  = 12'o7350;
    dval_b  = 16'hc9a2;
    dpm     = 4'b0101;
    resetN  = 1'b0;
    model_reset();
    repeat (3) step();
    check("rst_pulse", 64'(fa.btn_pulse), 64'(0));
    check("rst_level", 64'(fa.btn_level), 64'(0));
    check("rst_run", 64'(fa.run), 64'(0));
    check("rst_sel", 64'(fa.disp_sel), 64'(0));
    check("rst_an", 64'(fa.an), 64'(4'he));
    resetN = 1'b1;

    for (int i = 0; i < 9; i++) begin
      dpm = tab[i].dpm;
      step();
      check("scan_an_a", 64'(fa.an), 64'(tab[i].an_a));
      check("scan_seg_a", 64'(fa.seg), 64'(tab[i].seg_a));
      check("scan_dp_a", 64'(fa.dp), 64'(tab[i].dp_a));
      check("scan_an_b", 64'(fb.an), 64'(tab[i].an_b));
      check("scan_seg_b", 64'(fb.seg), 64'(tab[i].seg_b));
      check("scan_dp_b", 64'(fb.dp), 64'(tab[i].dp_b));
    end

    // short glitch on button 0 must be rejected
    btn_raw[0] = 1'b1;
    repeat (4) step();
    btn_raw[0] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (fa.btn_pulse[0] || fa.btn_level[0]) cnt++;
    end
    check("glitch", 64'(cnt), 64'(0));

    // button 2 held 40 cycles
    btn_raw[2] = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      step();
      if (fa.btn_pulse[2]) qa.push_back(c);
      if (fb.btn_pulse[2]) qb.push_back(c);
      if (c == 20) check("hold_level", 64'(fa.btn_level[2]), 64'(1));
      if (c == 40) btn_raw[2] = 1'b0;
    end
    check("hold_level_rel", 64'(fa.btn_level[2]), 64'(0));
    check("once_cnt", 64'(qa.size()), 64'(1));
    if (qa.size() > 0) check("once_pos", 64'(qa[0]), 64'(7));
    check("rep_cnt", 64'(qb.size()), 64'(5));
    for (int i = 0; i < qb.size() && i < 5; i++)
      check("rep_pos", 64'(qb[i]), 64'(exp_b_pos[i]));

    // run latch: set, halt, halt-vs-set collision
    run_sw = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 6) check("run_early", 64'(fa.run), 64'(0));
    end
    check("run_set", 64'(fa.run), 64'(1));
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("run_halt", 64'(fa.run), 64'(0));
    repeat (5) step();
    check("run_stay0", 64'(fa.run), 64'(0));
    run_sw = 1'b0;
    repeat (12) step();
    run_sw = 1'b1;
    repeat (6) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("run_collide", 64'(fa.run), 64'(0));
    repeat (3) step();
    check("run_collide2", 64'(fa.run), 64'(0));
    run_sw = 1'b0;
    repeat (10) step();

    // display-select wrap
    for (int p = 0; p < 5; p++) begin
      btn_raw[4] = 1'b1;
      repeat (10) step();
      btn_raw[4] = 1'b0;
      repeat (10) step();
      check("disp_sel", 64'(fa.disp_sel), 64'(exp_sel[p]));
    end

    // reset in the middle of a debounce
    btn_raw[1] = 1'b1;
    repeat (3) step();
    resetN = 1'b0;
    model_reset();
    #1;
    check("midrst", 64'(got_a()),
          64'({5'b0, 5'b0, 1'b0, 2'b0, 4'he, 7'h7f, 1'b1}));
    step();
    step();
    resetN = 1'b1;
    cnt = 0;
    pos = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (fa.btn_pulse[1]) begin
        cnt++;
        pos = c;
      end
    end
    check("midrst_cnt", 64'(cnt), 64'(1));
    check("midrst_pos", 64'(pos), 64'(7));
    btn_raw[1] = 1'b0;
    repeat (12) step();

    // random phase against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
      if ($urandom_range(0, 9) == 0) run_sw = ~run_sw;
      halt = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0) begin
        dval_a = 12'($urandom);
        dval_b = 16'($urandom);
        dpm    = 4'($urandom);
      end
      if (c == 1500) begin
        resetN = 1'b0;
        model_reset();
      end
      if (c == 1503) resetN = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
